// File: rtl/counter_checker.sv
// counter_checker: passive monitor for an up-counter with enable.
// It tracks the value the observed count must take next, flags deviations,
// keeps a saturating error count and a sticky error flag, and reports lock.
// Optional feature macro: COUNTER_CHECKER_FIRST_ERR_EN adds first_exp_o and
// first_obs_o, which capture the expected and observed values of the first
// mismatch seen since reset or the last clear.
module counter_checker #(
  parameter int WIDTH       = 32,
  parameter int LOSS_THRESH = 4,
  parameter int ERRCNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [WIDTH-1:0]    q_i,
  input  logic                clr_i,
  output logic                locked_o,
  output logic                err_o,
  output logic                err_sticky_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0]    exp_o,
  output logic                wrap_o
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  ,
  output logic [WIDTH-1:0]    first_exp_o,
  output logic [WIDTH-1:0]    first_obs_o
`endif
);

  // Run counter only has to reach LOSS_THRESH.
  localparam int RUN_W = $clog2(LOSS_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(LOSS_THRESH);

  typedef enum logic [0:0] {
    ST_ACQ   = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_exp;
  logic                r_locked;
  logic                r_err;
  logic                r_sticky;
  logic [ERRCNT_W-1:0] r_cnt;
  logic                r_wrap;
  logic [RUN_W-1:0]    r_run;

  logic [WIDTH-1:0]    w_sum;
  logic                w_mismatch;
  logic [RUN_W-1:0]    w_run_inc;
  logic                w_locked_nxt;
  logic                w_err_nxt;
  logic                w_sticky_nxt;
  logic [ERRCNT_W-1:0] w_cnt_nxt;
  logic                w_wrap_nxt;
  logic [RUN_W-1:0]    w_run_nxt;

  // Value the counter shows next; resync target on a mismatch too.
  assign w_sum      = q_i + WIDTH'(en_i);
  assign w_mismatch = (r_state == ST_TRACK) && (q_i != r_exp);
  assign w_run_inc  = r_run + {{(RUN_W-1){1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_ACQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, lock, pulse and error-accounting decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_locked_nxt = r_locked;
    w_err_nxt    = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_run_nxt    = r_run;
    w_sticky_nxt = r_sticky;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_ACQ: begin
        w_state_nxt  = ST_TRACK;
        w_locked_nxt = 1'b1;
        w_run_nxt    = {RUN_W{1'b0}};
      end
      ST_TRACK: begin
        if (w_mismatch) begin
          w_err_nxt = 1'b1;
          if (w_run_inc == RUN_LIM) begin
            w_state_nxt  = ST_ACQ;
            w_locked_nxt = 1'b0;
            w_run_nxt    = {RUN_W{1'b0}};
          end else begin
            w_state_nxt = ST_TRACK;
            w_run_nxt   = w_run_inc;
          end
        end else begin
          w_run_nxt  = {RUN_W{1'b0}};
          w_wrap_nxt = (&q_i) & en_i;
        end
      end
      default: begin
        w_state_nxt  = ST_ACQ;
        w_locked_nxt = 1'b0;
        w_run_nxt    = {RUN_W{1'b0}};
      end
    endcase
    // A mismatch on the clear edge still counts: the error wins.
    if (w_mismatch) begin
      w_sticky_nxt = 1'b1;
      if (clr_i) begin
        w_cnt_nxt = {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_cnt_nxt = sat_inc(r_cnt);
      end
    end else if (clr_i) begin
      w_sticky_nxt = 1'b0;
      w_cnt_nxt    = {ERRCNT_W{1'b0}};
    end else begin
      w_sticky_nxt = r_sticky;
      w_cnt_nxt    = r_cnt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_exp    <= {WIDTH{1'b0}};
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= {ERRCNT_W{1'b0}};
      r_wrap   <= 1'b0;
      r_run    <= {RUN_W{1'b0}};
    end else begin
      r_exp    <= w_sum;
      r_locked <= w_locked_nxt;
      r_err    <= w_err_nxt;
      r_sticky <= w_sticky_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wrap   <= w_wrap_nxt;
      r_run    <= w_run_nxt;
    end
  end

  assign locked_o     = r_locked;
  assign err_o        = r_err;
  assign err_sticky_o = r_sticky;
  assign err_cnt_o    = r_cnt;
  assign exp_o        = r_exp;
  assign wrap_o       = r_wrap;

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic [WIDTH-1:0] r_first_exp;
  logic [WIDTH-1:0] r_first_obs;
  logic             w_capture;

  // Capture is armed while no error is recorded, or being cleared this edge.
  assign w_capture = w_mismatch && (!r_sticky || clr_i);

  // First-mismatch capture registers; clear rearms and zeroes them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_first_exp <= {WIDTH{1'b0}};
      r_first_obs <= {WIDTH{1'b0}};
    end else if (w_capture) begin
      r_first_exp <= r_exp;
      r_first_obs <= q_i;
    end else if (clr_i) begin
      r_first_exp <= {WIDTH{1'b0}};
      r_first_obs <= {WIDTH{1'b0}};
    end else begin
      r_first_exp <= r_first_exp;
      r_first_obs <= r_first_obs;
    end
  end

  assign first_exp_o = r_first_exp;
  assign first_obs_o = r_first_obs;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Directed self-checking bench for counter_checker. A second instance with a
// 4-bit error counter shares the stimulus to exercise saturation.
module tb_counter_checker;
  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic [W-1:0]  q_i;
  logic          clr_i;

  logic          locked_o, err_o, sticky_o, wrap_o;
  logic [15:0]   cnt_o;
  logic [W-1:0]  exp_o;
  logic          s_locked_o, s_err_o, s_sticky_o, s_wrap_o;
  logic [3:0]    s_cnt_o;
  logic [W-1:0]  s_exp_o;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic [W-1:0]  first_exp_o, first_obs_o, s_first_exp_o, s_first_obs_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  counter_checker #(.WIDTH(W), .LOSS_THRESH(4), .ERRCNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .q_i(q_i), .clr_i(clr_i),
    .locked_o(locked_o), .err_o(err_o), .err_sticky_o(sticky_o),
    .err_cnt_o(cnt_o), .exp_o(exp_o), .wrap_o(wrap_o)
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    , .first_exp_o(first_exp_o), .first_obs_o(first_obs_o)
`endif
  );

  counter_checker #(.WIDTH(W), .LOSS_THRESH(4), .ERRCNT_W(4)) u_dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .q_i(q_i), .clr_i(clr_i),
    .locked_o(s_locked_o), .err_o(s_err_o), .err_sticky_o(s_sticky_o),
    .err_cnt_o(s_cnt_o), .exp_o(s_exp_o), .wrap_o(s_wrap_o)
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    , .first_exp_o(s_first_exp_o), .first_obs_o(s_first_obs_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] q, input logic en);
    q_i  = q;
    en_i = en;
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] cnt;
    logic [15:0]  lfsr;
    logic         en_b;
    rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; q_i = '0;
    tick(); tick();
    check("rst_locked", 64'(locked_o), 64'd0);
    check("rst_err",    64'(err_o),    64'd0);
    check("rst_sticky", 64'(sticky_o), 64'd0);
    check("rst_cnt",    64'(cnt_o),    64'd0);
    check("rst_exp",    64'(exp_o),    64'd0);
    check("rst_wrap",   64'(wrap_o),   64'd0);
    rst_i = 1'b0;

    // Clean counting with pseudo-random enable (LFSR seeded with 123).
    cnt  = '0;
    lfsr = 16'd123;
    for (int i = 0; i < 1000; i++) begin
      en_b = lfsr[0];
      drive(cnt, en_b);
      cnt  = cnt + W'(en_b);
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      check("t1_locked", 64'(locked_o), 64'd1);
      check("t1_err",    64'(err_o),    64'd0);
      check("t1_exp",    64'(exp_o),    64'(cnt));
    end
    check("t1_cnt",    64'(cnt_o),    64'd0);
    check("t1_sticky", 64'(sticky_o), 64'd0);

    // Single glitch: one error, resync, lock kept.
    do_reset();
    drive(32'h0, 1'b1);
    for (int v = 1; v <= 16; v++) drive(W'(v), 1'b1);
    check("t2_exp11", 64'(exp_o), 64'h11);
    drive(32'h15, 1'b1);
    check("t2_err",    64'(err_o),    64'd1);
    check("t2_cnt",    64'(cnt_o),    64'd1);
    check("t2_exp",    64'(exp_o),    64'h16);
    check("t2_locked", 64'(locked_o), 64'd1);
    check("t2_sticky", 64'(sticky_o), 64'd1);
    drive(32'h16, 1'b1);
    check("t2_err_off", 64'(err_o), 64'd0);
    check("t2_exp17",   64'(exp_o), 64'h17);
    drive(32'h17, 1'b1);
    drive(32'h18, 1'b1);
    check("t2_noerr", 64'(err_o), 64'd0);
    check("t2_cnt1",  64'(cnt_o), 64'd1);

    // Clear alone.
    clr_i = 1'b1;
    drive(32'h19, 1'b1);
    clr_i = 1'b0;
    check("clr_sticky", 64'(sticky_o), 64'd0);
    check("clr_cnt",    64'(cnt_o),    64'd0);
    check("clr_exp",    64'(exp_o),    64'h1A);
    check("clr_locked", 64'(locked_o), 64'd1);

    // Four consecutive mismatches drop lock; next edge reacquires.
    for (int k = 0; k < 4; k++) begin
      drive(W'(32'h100 + k), 1'b0);
      check("t3_err",    64'(err_o),    64'd1);
      check("t3_cnt",    64'(cnt_o),    64'(k + 1));
      check("t3_locked", 64'(locked_o), (k < 3) ? 64'd1 : 64'd0);
    end
    drive(32'h200, 1'b1);
    check("t3_reacq",   64'(locked_o), 64'd1);
    check("t3_acq_err", 64'(err_o),    64'd0);
    check("t3_acq_exp", 64'(exp_o),    64'h201);
    drive(32'h201, 1'b1);
    drive(32'h202, 1'b1);
    check("t3_clean_err", 64'(err_o), 64'd0);
    check("t3_clean_cnt", 64'(cnt_o), 64'd4);

    // Wrap from all-ones to zero.
    do_reset();
    drive(32'hFFFF_FFFD, 1'b1);
    check("t4_wrap0", 64'(wrap_o), 64'd0);
    check("t4_expFE", 64'(exp_o),  64'hFFFF_FFFE);
    drive(32'hFFFF_FFFE, 1'b1);
    check("t4_wrap1", 64'(wrap_o), 64'd0);
    drive(32'hFFFF_FFFF, 1'b1);
    check("t4_wrap",  64'(wrap_o), 64'd1);
    check("t4_exp0",  64'(exp_o),  64'd0);
    check("t4_err",   64'(err_o),  64'd0);
    drive(32'h0, 1'b1);
    check("t4_wrap_off", 64'(wrap_o), 64'd0);
    check("t4_exp1",     64'(exp_o),  64'd1);

    // Clear coinciding with a mismatch: error wins.
    drive(32'h5, 1'b0);
    check("t5_err",    64'(err_o),    64'd1);
    check("t5_cnt",    64'(cnt_o),    64'd1);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check("t5_fexp",   64'(first_exp_o), 64'd1);
    check("t5_fobs",   64'(first_obs_o), 64'd5);
`endif
    drive(32'h5, 1'b0);
    clr_i = 1'b1;
    drive(32'h9, 1'b0);
    clr_i = 1'b0;
    check("t5_clr_sticky", 64'(sticky_o), 64'd1);
    check("t5_clr_cnt",    64'(cnt_o),    64'd1);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check("t5_clr_fexp", 64'(first_exp_o), 64'd5);
    check("t5_clr_fobs", 64'(first_obs_o), 64'd9);
`endif
    drive(32'hC, 1'b0);
    check("t5_cnt2", 64'(cnt_o), 64'd2);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check("t5_hold_fexp", 64'(first_exp_o), 64'd5);
    check("t5_hold_fobs", 64'(first_obs_o), 64'd9);
`endif
    drive(32'hC, 1'b0);

    // Saturation of the 4-bit counter; 16-bit counter keeps counting.
    clr_i = 1'b1;
    drive(32'hC, 1'b0);
    clr_i = 1'b0;
    check("t6_clr_s", 64'(s_cnt_o), 64'd0);
    for (int i = 0; i < 20; i++) begin
      drive(W'(13 + i), 1'b0);
      check("t6_scnt", 64'(s_cnt_o), (i < 15) ? 64'(i + 1) : 64'd15);
      check("t6_cnt",  64'(cnt_o),   64'(i + 1));
      drive(W'(13 + i), 1'b0);
      check("t6_match", 64'(err_o), 64'd0);
    end
    drive(32'd100, 1'b0);
    check("t6_scnt_hold", 64'(s_cnt_o),  64'd15);
    check("t6_cnt21",     64'(cnt_o),    64'd21);
    check("t6_locked",    64'(locked_o), 64'd1);

    // Asynchronous reset mid-cycle.
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_locked", 64'(locked_o), 64'd0);
    check("ar_err",    64'(err_o),    64'd0);
    check("ar_sticky", 64'(sticky_o), 64'd0);
    check("ar_cnt",    64'(cnt_o),    64'd0);
    check("ar_exp",    64'(exp_o),    64'd0);
    check("ar_scnt",   64'(s_cnt_o),  64'd0);
    check("ar_ssticky",64'(s_sticky_o), 64'd0);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    check("ar_fexp", 64'(first_exp_o), 64'd0);
    check("ar_fobs", 64'(first_obs_o), 64'd0);
`endif
    tick();
    rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
Passive monitor at the far end of a counter's output bus: it samples the counter's enable and count value and tracks the value the count must take next. It flags any deviation, counts errors and reports lock status. It sits beside a counter (or on its `q` bus downstream) in test designs, where it gives pass/fail indication without a waveform dump.

Parameters:
WIDTH, 32, width of observed count bus
LOSS_THRESH, 4, consecutive mismatches that drop lock and force reacquire (>=1)
ERRCNT_W, 16, width of saturating error counter

Ports:
clk_i  in  1  clock, rising edge; the same clock as the observed counter
rst_i  in  1  asynchronous, active-high reset
en_i  in  1  enable seen by the observed counter in the same cycle
q_i  in  WIDTH  count value from the observed counter
clr_i  in  1  synchronous clear of err_cnt_o and err_sticky_o
locked_o  out  1  checker is tracking the counter
err_o  out  1  one-cycle pulse on a detected mismatch
err_sticky_o  out  1  set on any error, held until clr_i or reset
err_cnt_o  out  ERRCNT_W  saturating mismatch count
exp_o  out  WIDTH  value q_i must show at the next sample
wrap_o  out  1  one-cycle pulse when the tracked count wraps from all-ones to 0

Behaviour:
- Reset (async assert, sync release): state=ACQ, exp_o=0, locked_o=0, err_o=0, err_sticky_o=0, err_cnt_o=0, wrap_o=0, mismatch run counter=0.
- Counter model: the observed counter updates `q(n+1) = q(n) + en(n)` modulo 2^WIDTH. Both `q_i` and `en_i` are sampled on each rising edge.
- State ACQ:
  - On each edge: `exp <= q_i + en_i` (WIDTH bits, wrapping); go to TRACK; set `locked_o` to 1 from that edge onward.
  - `err_o` is never asserted in ACQ.
- State TRACK, on each edge, compare sampled `q_i` with `exp`:
  - Match: `exp <= q_i + en_i`; run counter <= 0.
  - Mismatch:
    - `err_o` = 1 for exactly the next cycle.
    - `err_sticky_o` <= 1.
    - `err_cnt_o` increments, saturating at all-ones.
    - run counter increments.
    - `exp <= q_i + en_i` (resync to the observed value, so a single glitch costs one error, not a stream).
    - If run counter reaches LOSS_THRESH: go to ACQ, `locked_o` <= 0, run counter <= 0.
- `wrap_o`: pulses 1 cycle when a match occurs with `q_i` = all-ones and `en_i` = 1 (next exp = 0). It is not asserted in ACQ or on a mismatch.
- `clr_i`:
  - Clears `err_sticky_o` and `err_cnt_o` at the edge.
  - If a mismatch is detected on the same edge, the error wins: sticky = 1, count = 1.
  - It does not affect state, `exp` or `locked_o`.
- `en_i`=0 with `q_i` unchanged is a match. `en_i`=0 with `q_i` changed is a mismatch.
- `exp_o` is a registered output equal to the internal `exp`. All outputs are registered; no combinational input-to-output path.
- `rst_i` asserted mid-run immediately returns all state to the reset values. The first edge after release re-enters ACQ behaviour.

Optional Feature:
Macro: COUNTER_CHECKER_FIRST_ERR_EN.
- Defined:
  - Adds outputs `first_exp_o [WIDTH]` and `first_obs_o [WIDTH]`.
  - On the first mismatch while `err_sticky_o`=0 (including a mismatch coinciding with `clr_i`), these capture `exp` and `q_i`, then hold.
  - Reset values are 0; `clr_i` rearms capture and zeroes both outputs.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then drive a 32-bit counter with pseudo-random `en_i` (seed 123) for 1000 cycles -> `locked_o`=1 from cycle 1; `err_o` never 1; `err_cnt_o`=0; `err_sticky_o`=0.
- Locked with `q_i`=0x10, `en_i`=1 -> next expected 0x11; force `q_i`=0x15 -> `err_o` 1 cycle; `err_cnt_o`=1; `exp_o`=0x15+en; `locked_o` stays 1; following correct counts give no further errors.
- LOSS_THRESH=4; force 4 consecutive wrong values -> `err_cnt_o`=4; `locked_o`=0 after the 4th; the next edge reacquires, `locked_o`=1; clean counting afterwards gives no errors.
- Preload the counter near 0xFFFFFFFF with `en_i`=1 -> `wrap_o` pulses once when 0xFFFFFFFF→0; `exp_o`=0; no error.
- `clr_i` asserted alone -> `err_sticky_o`=0 and `err_cnt_o`=0. `clr_i` on the same edge as a mismatch -> sticky=1, count=1. With COUNTER_CHECKER_FIRST_ERR_EN: `first_exp_o`/`first_obs_o` capture only the first mismatch.
- Error count saturation with ERRCNT_W=4: 20 mismatches -> `err_cnt_o`=15 and holds. Then assert `rst_i` mid-stream -> all outputs return to 0 asynchronously.
